// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder/loader.
// IMEM_CHECKSUM_EN adds the S_CSUM state used for the image trailer word.
package imem_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_DONE = 3'd4
    } imem_state_e;

endpackage

// File: rtl/imem_loader_responder_if.sv
// Fetch port and image-loader byte port of the instruction memory.
// The slave modport is the memory side; the master modport is the CPU/UART side.
interface imem_loader_responder_if;

    // Fetch: fetch_req/pc in one cycle -> inst_valid/inst_fault/instruction next cycle.
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        inst_fault;

    // Byte port: a byte transfers on a rising clk edge where ld_byte_valid and
    // ld_ready are both 1; the sender holds ld_byte stable until then and
    // ld_ready never depends on ld_byte_valid.
    logic        ld_start;
    logic [7:0]  ld_byte;
    logic        ld_byte_valid;
    logic        ld_ready;
    logic        loading;
    logic        ld_done;
    logic        ld_overflow;
    logic        ld_csum_err;

    modport master (
        output fetch_req, pc, ld_start, ld_byte, ld_byte_valid,
        input  instruction, inst_valid, inst_fault,
        input  ld_ready, loading, ld_done, ld_overflow, ld_csum_err
    );

    modport slave (
        input  fetch_req, pc, ld_start, ld_byte, ld_byte_valid,
        output instruction, inst_valid, inst_fault,
        output ld_ready, loading, ld_done, ld_overflow, ld_csum_err
    );

endinterface

// File: rtl/imem_byte_assembler.sv
// Packs accepted image bytes little-endian into 32-bit words and pulses
// word_valid in the cycle after the fourth byte of each word.
module imem_byte_assembler
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    lane_t lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= '0;
                word <= '0;
            end else if (take) begin
                // Shifting right leaves the first byte in [7:0] after four bytes.
                word <= {byte_in, word[31:8]};
                lane <= lane + lane_t'(1);
                if (lane == lane_t'(WORD_BYTES - 1)) begin
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader_responder.sv
// Instruction memory: one-cycle fetch responder plus a byte-stream image loader.
// Define IMEM_CHECKSUM_EN to require and verify a sum trailer after the image.
module imem_loader_responder
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    imem_loader_responder_if.slave bus,
    output imem_state_e            state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;

    logic        out_nop_q;
    logic        inst_valid_q;
    logic        inst_fault_q;
    logic        loading_q;
    logic        ld_done_q;
    logic        ld_overflow_q;
    logic        ld_csum_err_q;
    logic [31:0] n_words;
    logic [31:0] wcount;
    logic [31:0] csum;

    logic        start_acc;
    logic        take;
    logic        word_valid;
    logic [31:0] word;
    logic        in_csum;
    logic [31:0] pc_off;
    logic        fetch_ok;
    logic        rd_en;
    logic        in_range_w;
    logic        wr_en;
    logic [31:0] csum_next;

`ifdef IMEM_CHECKSUM_EN
    assign in_csum = (state == S_CSUM);
`else
    assign in_csum = 1'b0;
`endif

    assign start_acc    = (state == S_RUN) && bus.ld_start;
    assign bus.ld_ready = ((state == S_LEN) || (state == S_DATA) || in_csum) && !word_valid;
    assign take         = bus.ld_byte_valid && bus.ld_ready;

    // BASE_ADDR is word-aligned, so the offset's low bits are the pc's low bits.
    assign pc_off   = bus.pc - BASE_ADDR;
    assign fetch_ok = (pc_off[1:0] == 2'b00) && (pc_off[31:ADDR_WIDTH+2] == '0);
    assign rd_en    = (state == S_RUN) && bus.fetch_req && !bus.ld_start && fetch_ok;

    assign in_range_w = (wcount[31:ADDR_WIDTH] == '0);
    assign wr_en      = (state == S_DATA) && word_valid && in_range_w;
    assign csum_next  = csum + word;

    imem_byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_acc),
        .take       (take),
        .byte_in    (bus.ld_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // Plain write/read ports without reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wcount[ADDR_WIDTH-1:0]] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_q <= mem[pc_off[ADDR_WIDTH+1:2]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RUN;
            out_nop_q     <= 1'b1;
            inst_valid_q  <= 1'b0;
            inst_fault_q  <= 1'b0;
            loading_q     <= 1'b0;
            ld_done_q     <= 1'b0;
            ld_overflow_q <= 1'b0;
            ld_csum_err_q <= 1'b0;
            n_words       <= '0;
            wcount        <= '0;
            csum          <= '0;
        end else begin
            ld_done_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            case (state)
                S_RUN: begin
                    if (bus.ld_start) begin
                        state         <= S_LEN;
                        loading_q     <= 1'b1;
                        out_nop_q     <= 1'b1;
                        inst_fault_q  <= 1'b0;
                        ld_overflow_q <= 1'b0;
                        ld_csum_err_q <= 1'b0;
                        wcount        <= '0;
                        csum          <= '0;
                    end else if (bus.fetch_req) begin
                        inst_valid_q <= 1'b1;
                        inst_fault_q <= !fetch_ok;
                        out_nop_q    <= !fetch_ok;
                    end
                end
                S_LEN: begin
                    if (word_valid) begin
                        n_words <= word;
                        if (word == '0) begin
`ifdef IMEM_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state     <= S_DONE;
                            loading_q <= 1'b0;
                            ld_done_q <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        csum   <= csum_next;
                        wcount <= wcount + 32'd1;
                        if (!in_range_w) begin
                            ld_overflow_q <= 1'b1;
                        end
                        if (wcount + 32'd1 == n_words) begin
`ifdef IMEM_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state     <= S_DONE;
                            loading_q <= 1'b0;
                            ld_done_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                S_CSUM: begin
                    if (word_valid) begin
                        ld_csum_err_q <= (word != csum);
                        state         <= S_DONE;
                        loading_q     <= 1'b0;
                        ld_done_q     <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    assign bus.instruction = out_nop_q ? NOP_WORD : rd_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst_fault  = inst_fault_q;
    assign bus.loading     = loading_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.ld_overflow = ld_overflow_q;
`ifdef IMEM_CHECKSUM_EN
    assign bus.ld_csum_err = ld_csum_err_q;
`else
    assign bus.ld_csum_err = 1'b0;
`endif

endmodule
